cde_tick_timer: RTL and testbench

Programmable countdown timer that consumes the single-cycle enable pulse produced by the prescaler stage and counts prescaled ticks down to expiry. It raises a one-cycle expiry strobe and a sticky interrupt that is cleared by acknowledge. It sits directly downstream of the prescaler and gives the peripheral/bus layer a coarse-grained timebase. Periodic auto-reload is optional at compile time.

---
 rtl/cde_tick_timer.sv | 136 +++++++++++++
 tb/tb_cde_tick_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cde_tick_timer.sv
// cde_tick_timer
// Programmable countdown timer driven by a prescaled single-cycle tick.
// Counts ticks down from a reload value, pulses `expired` for one cycle on
// reaching expiry and latches a sticky `irq` until `irq_ack`.
//
// Compile-time option: define CDE_TICK_TIMER_RELOAD_EN to honour the
// `periodic` input (auto-reload on expiry). Without it the timer is always
// one-shot and `periodic` is ignored.
//
// Per-cycle priority: stop > load > start > tick_in.
// All outputs are registered; there is no combinational input-to-output path.
//
// Handshake note: there is no valid/ready pairing on this block. Every
// control input is a level sampled on each rising clk edge and acts in that
// cycle only; tick_in is expected to be one clk wide per tick but holding it
// high is legal and yields one decrement per cycle while in RUN.

module cde_tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             irq,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_running;
  logic             r_expired;
  logic             r_irq;

  logic             w_periodic;
  logic             w_reload_nz;
  logic             w_at_expiry;
  logic             w_tick_run;

`ifdef CDE_TICK_TIMER_RELOAD_EN
  // Auto-reload select taken straight from the input.
  assign w_periodic = periodic;
`else
  // One-shot only; the periodic input is deliberately left unused.
  logic w_unused_periodic;
  assign w_unused_periodic = periodic;
  assign w_periodic        = 1'b0;
`endif

  // Start is only honoured when there is something to count down from.
  assign w_reload_nz = (r_reload != '0);

  // A count of 1 expires on the next tick; a forced count of 0 in RUN is
  // treated the same way so 0 is never decremented and no wrap can occur.
  assign w_at_expiry = (r_count <= {{(WIDTH-1){1'b0}}, 1'b1});

  // Tick that is actually consumed by the counter this cycle.
  assign w_tick_run = (r_state == ST_RUN) && tick_in;

  // Timer state machine with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      // Expiry strobe is one cycle wide unless re-armed below.
      r_expired <= 1'b0;

      // Acknowledge clears irq; a same-cycle expiry below overrides it.
      if (irq_ack) begin
        r_irq <= 1'b0;
      end

      if (stop) begin
        // Stop wins over everything: count and reload are held, any
        // coincident tick or expiry is dropped.
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
      end else if (load) begin
        // Load replaces both the reload value and the live count without
        // changing state; a coincident tick is lost.
        r_reload <= load_value;
        r_count  <= load_value;
      end else if (start && (r_state != ST_RUN)) begin
        // Arm from the reload register; a zero reload leaves state alone.
        if (w_reload_nz) begin
          r_count   <= r_reload;
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
      end else if (w_tick_run) begin
        if (w_at_expiry) begin
          r_expired <= 1'b1;
          r_irq     <= 1'b1;
          if (w_periodic) begin
            // Reload on the expiring tick so the next period is exactly
            // N ticks long with no lost or extra tick at the boundary.
            r_count <= r_reload;
          end else begin
            r_count   <= '0;
            r_state   <= ST_DONE;
            r_running <= 1'b0;
          end
        end else begin
          r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign count     = r_count;
  assign running   = r_running;
  assign expired   = r_expired;
  assign irq       = r_irq;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_cde_tick_timer.sv
// Directed testbench for cde_tick_timer.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at the
// same point, after the edge has settled.

module tb_cde_tick_timer;

  localparam int W = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Clock and reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         tick_in = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         periodic = 1'b0;
  logic         irq_ack = 1'b0;
  logic [W-1:0] count;
  logic         running;
  logic         expired;
  logic         irq;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  cde_tick_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_in    (tick_in),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .periodic   (periodic),
    .irq_ack    (irq_ack),
    .count      (count),
    .running    (running),
    .expired    (expired),
    .irq        (irq),
    .state_dbg  (state_dbg)
  );

  // Driver: advance one clock and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick_in = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_value = v; cyc(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_tick();
    tick_in = 1'b1; cyc(); tick_in = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({running, expired, irq} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {running, expired, irq}); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    do_load(16'd7);
    do_start();
    checks++; if (count !== 16'd7 || running !== 1'b1) begin errors++; $display("FAIL reset_prerun got count=%0d run=%b exp 7/1", count, running); end
    // Asynchronous reset mid-count, checked before the next clock edge.
    #2 reset_n = 1'b0;
    #1;
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_async_count got=%0d exp=0", count); end
    checks++; if ({running, expired, irq} !== 3'b000) begin errors++; $display("FAIL reset_async_flags got=%b exp=000", {running, expired, irq}); end
    cyc();
    reset_n = 1'b1;
    cyc();
    // Reload register is 0 after reset, so start must be ignored.
    do_start();
    checks++; if (running !== 1'b0 || state_dbg !== S_IDLE || count !== 16'd0) begin errors++; $display("FAIL reset_start_ignored got run=%b st=%0d cnt=%0d exp 0/0/0", running, state_dbg, count); end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_cnt;
    do_load(16'd3);
    do_start();
    checks++; if (count !== 16'd3 || running !== 1'b1) begin errors++; $display("FAIL oneshot_start got cnt=%0d run=%b exp 3/1", count, running); end
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      exp_cnt = 16'(3 - k);
      checks++; if (count !== exp_cnt) begin errors++; $display("FAIL oneshot_count%0d got=%0d exp=%0d", k, count, exp_cnt); end
      checks++; if (expired !== (k == 3)) begin errors++; $display("FAIL oneshot_expired%0d got=%b exp=%b", k, expired, (k == 3)); end
      for (int g = 0; g < 3; g++) begin
        cyc();
        checks++; if (expired !== 1'b0) begin errors++; $display("FAIL oneshot_strobe_width%0d got=%b exp=0", k, expired); end
      end
    end
    checks++; if (state_dbg !== S_DONE || running !== 1'b0) begin errors++; $display("FAIL oneshot_done got st=%0d run=%b exp 2/0", state_dbg, running); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_sticky got=%b exp=1", irq); end
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_ack got=%b exp=0", irq); end
  endtask

  task automatic test_periodic();
    logic [W-1:0] exp_cnt;
    logic         exp_exp;
    int           pulses;
    pulses = 0;
    periodic = 1'b1;
    do_load(16'd2);
    do_start();
    tick_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
`ifdef CDE_TICK_TIMER_RELOAD_EN
      exp_cnt = (k % 2 == 1) ? 16'd1 : 16'd2;
      exp_exp = (k % 2 == 0);
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL periodic_running%0d got=%b exp=1", k, running); end
`else
      exp_cnt = (k == 1) ? 16'd1 : 16'd0;
      exp_exp = (k == 2);
`endif
      if (expired === 1'b1) pulses++;
      checks++; if (count !== exp_cnt) begin errors++; $display("FAIL periodic_count%0d got=%0d exp=%0d", k, count, exp_cnt); end
      checks++; if (expired !== exp_exp) begin errors++; $display("FAIL periodic_expired%0d got=%b exp=%b", k, expired, exp_exp); end
    end
    tick_in = 1'b0;
`ifdef CDE_TICK_TIMER_RELOAD_EN
    checks++; if (pulses !== 3) begin errors++; $display("FAIL periodic_pulses got=%0d exp=3", pulses); end
`else
    checks++; if (pulses !== 1) begin errors++; $display("FAIL periodic_pulses got=%0d exp=1", pulses); end
    checks++; if (state_dbg !== S_DONE) begin errors++; $display("FAIL periodic_done got=%0d exp=%0d", state_dbg, S_DONE); end
`endif
    periodic = 1'b0;
    stop = 1'b1; irq_ack = 1'b1; cyc(); stop = 1'b0; irq_ack = 1'b0;
    checks++; if (state_dbg !== S_IDLE || irq !== 1'b0) begin errors++; $display("FAIL periodic_stop got st=%0d irq=%b exp 0/0", state_dbg, irq); end
  endtask

  task automatic test_priority();
    do_load(16'd5);
    do_start();
    checks++; if (count !== 16'd5 || state_dbg !== S_RUN) begin errors++; $display("FAIL prio_arm got cnt=%0d st=%0d exp 5/1", count, state_dbg); end
    stop = 1'b1; load = 1'b1; load_value = 16'd12; tick_in = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (count !== 16'd5 || state_dbg !== S_IDLE || running !== 1'b0) begin errors++; $display("FAIL prio_stop got cnt=%0d st=%0d run=%b exp 5/0/0", count, state_dbg, running); end
    // Reload register must still hold 5 after the suppressed load.
    do_start();
    checks++; if (count !== 16'd5 || running !== 1'b1) begin errors++; $display("FAIL prio_reload_kept got cnt=%0d run=%b exp 5/1", count, running); end
    load = 1'b1; load_value = 16'd9; tick_in = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (count !== 16'd9 || state_dbg !== S_RUN) begin errors++; $display("FAIL prio_load_over_tick got cnt=%0d st=%0d exp 9/1", count, state_dbg); end
    do_tick();
    checks++; if (count !== 16'd8) begin errors++; $display("FAIL prio_tick_after_load got=%0d exp=8", count); end
  endtask

  task automatic test_irq_race();
    do_load(16'd1);
    checks++; if (count !== 16'd1 || state_dbg !== S_RUN) begin errors++; $display("FAIL race_load_run got cnt=%0d st=%0d exp 1/1", count, state_dbg); end
    tick_in = 1'b1; irq_ack = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (expired !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL race_irq_kept got exp=%b irq=%b exp 1/1", expired, irq); end
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_irq_ack got=%b exp=0", irq); end
  endtask

  task automatic test_restart();
    // Timer is in DONE with count 0; load does not change state.
    do_load(16'd4);
    checks++; if (state_dbg !== S_DONE || count !== 16'd4) begin errors++; $display("FAIL restart_load_done got st=%0d cnt=%0d exp 2/4", state_dbg, count); end
    // Tick arriving together with start is ignored (not yet in RUN).
    start = 1'b1; tick_in = 1'b1; cyc(); start = 1'b0; tick_in = 1'b0;
    checks++; if (count !== 16'd4 || running !== 1'b1) begin errors++; $display("FAIL restart_start got cnt=%0d run=%b exp 4/1", count, running); end
    tick_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++; if (expired !== (k == 4)) begin errors++; $display("FAIL restart_expired%0d got=%b exp=%b", k, expired, (k == 4)); end
    end
    tick_in = 1'b0;
    checks++; if (count !== 16'd0 || state_dbg !== S_DONE || irq !== 1'b1) begin errors++; $display("FAIL restart_done got cnt=%0d st=%0d irq=%b exp 0/2/1", count, state_dbg, irq); end
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Reload of 1 with tick held high: immediate expiry, then DONE ignores ticks.
    do_load(16'd1);
    do_start();
    tick_in = 1'b1;
    cyc();
    checks++; if (expired !== 1'b1 || state_dbg !== S_DONE) begin errors++; $display("FAIL b2b_expire got exp=%b st=%0d exp 1/2", expired, state_dbg); end
    cyc();
    tick_in = 1'b0;
    checks++; if (expired !== 1'b0 || count !== 16'd0) begin errors++; $display("FAIL b2b_done_hold got exp=%b cnt=%0d exp 0/0", expired, count); end
    // Stop from DONE returns to IDLE with count held.
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++; if (state_dbg !== S_IDLE || count !== 16'd0) begin errors++; $display("FAIL b2b_stop_done got st=%0d cnt=%0d exp 0/0", state_dbg, count); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_priority();
    test_irq_race();
    test_restart();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
